// File: rtl/data_memory.sv
// Data RAM for the CPU with one write port and one registered read port.
// Read-first on a same-address collision. Reset clears the array and the read register.
module data_memory #(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDRESS_WIDTH     = 4,
  parameter int ADDRESS_MAX_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [ADDRESS_WIDTH-1:0] write_address,
  input  logic                     Write_Enable,
  input  logic [DATA_WIDTH-1:0]    DATA_WRITE,
  input  logic [ADDRESS_WIDTH-1:0] read_address,
  input  logic                     Read_Enable,
  output logic [DATA_WIDTH-1:0]    DATA_READ
);

  logic [DATA_WIDTH-1:0] mem_q [ADDRESS_MAX_WIDTH];
  logic [DATA_WIDTH-1:0] mem_d [ADDRESS_MAX_WIDTH];
  logic [DATA_WIDTH-1:0] data_read_q;
  logic [DATA_WIDTH-1:0] data_read_d;

  // Decode by comparing against every implemented index. An address at or
  // beyond the depth matches no entry, so out-of-range writes are dropped and
  // out-of-range reads return zero without needing a separate range check.
  always_comb begin
    for (int i = 0; i < ADDRESS_MAX_WIDTH; i++) begin
      mem_d[i] = mem_q[i];
      if (Write_Enable && (32'(write_address) == i)) begin
        mem_d[i] = DATA_WRITE;
      end
    end
  end

  // Sourced from mem_q (pre-write contents), which gives read-first behaviour.
  always_comb begin
    data_read_d = data_read_q;
    if (Read_Enable) begin
      data_read_d = '0;
      for (int i = 0; i < ADDRESS_MAX_WIDTH; i++) begin
        if (32'(read_address) == i) begin
          data_read_d = mem_q[i];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ADDRESS_MAX_WIDTH; i++) begin
        mem_q[i] <= '0;
      end
      data_read_q <= '0;
    end else begin
      for (int i = 0; i < ADDRESS_MAX_WIDTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      data_read_q <= data_read_d;
    end
  end

  assign DATA_READ = data_read_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: stimulus pushes the expected DATA_READ for
// each edge into a queue, and an independent monitor pops and compares.
module tb_data_memory;

  logic       clock;
  logic       reset_n;
  logic [3:0] write_address;
  logic       Write_Enable;
  logic [7:0] DATA_WRITE;
  logic [3:0] read_address;
  logic       Read_Enable;
  logic [7:0] DATA_READ;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  event chk_now;

  data_memory #(
    .DATA_WIDTH       (8),
    .ADDRESS_WIDTH    (4),
    .ADDRESS_MAX_WIDTH(16)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .write_address(write_address),
    .Write_Enable (Write_Enable),
    .DATA_WRITE   (DATA_WRITE),
    .read_address (read_address),
    .Read_Enable  (Read_Enable),
    .DATA_READ    (DATA_READ)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change 1 ns after a falling edge, so any entry in the queue at a
  // falling edge belongs to the rising edge just before it.
  always begin
    @(negedge clock or chk_now);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (DATA_READ !== e.exp) begin
        n_errors++;
        $display("FAIL %s: DATA_READ=0x%02h expected 0x%02h", e.name, DATA_READ, e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 100000 ns");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  task automatic step(input string name, input logic we, input logic [3:0] wa,
                      input logic [7:0] wd, input logic re, input logic [3:0] ra,
                      input logic [7:0] exp);
    @(negedge clock);
    #1;
    Write_Enable  = we;
    write_address = wa;
    DATA_WRITE    = wd;
    Read_Enable   = re;
    read_address  = ra;
    exp_q.push_back('{name, exp});
    @(posedge clock);
  endtask

  task automatic async_check(input string name, input logic [7:0] exp);
    exp_q.push_back('{name, exp});
    ->chk_now;
    #1;
  endtask

  initial begin
    reset_n       = 1'b0;
    Write_Enable  = 1'b0;
    write_address = '0;
    DATA_WRITE    = '0;
    Read_Enable   = 1'b0;
    read_address  = '0;
    #3;
    async_check("reset_value", 8'h00);
    @(negedge clock);
    #1;
    reset_n = 1'b1;

    step("hold_after_reset",  1'b0, 4'h0, 8'h00, 1'b0, 4'h9, 8'h00);
    step("read9_empty",       1'b0, 4'h0, 8'h00, 1'b1, 4'h9, 8'h00);
    step("write9_no_read",    1'b1, 4'h9, 8'hC5, 1'b0, 4'h9, 8'h00);
    step("read9_c5",          1'b0, 4'h0, 8'h00, 1'b1, 4'h9, 8'hC5);
    step("hold_c5",           1'b0, 4'h0, 8'h00, 1'b0, 4'h3, 8'hC5);
    step("write_f",           1'b1, 4'hF, 8'h09, 1'b0, 4'h3, 8'hC5);
    step("write_1",           1'b1, 4'h1, 8'h0F, 1'b0, 4'h3, 8'hC5);
    step("read_f",            1'b0, 4'h0, 8'h00, 1'b1, 4'hF, 8'h09);
    step("read_1",            1'b0, 4'h0, 8'h00, 1'b1, 4'h1, 8'h0F);
    step("reread9",           1'b0, 4'h0, 8'h00, 1'b1, 4'h9, 8'hC5);
    step("we0_no_write",      1'b0, 4'h9, 8'hAA, 1'b0, 4'h9, 8'hC5);
    step("read9_unchanged",   1'b0, 4'h0, 8'h00, 1'b1, 4'h9, 8'hC5);
    step("collide_read_old",  1'b1, 4'h5, 8'h3C, 1'b1, 4'h5, 8'h00);
    step("read5_new",         1'b0, 4'h0, 8'h00, 1'b1, 4'h5, 8'h3C);
    step("write2_read_other", 1'b1, 4'h2, 8'h77, 1'b1, 4'h9, 8'hC5);
    step("read2",             1'b0, 4'h0, 8'h00, 1'b1, 4'h2, 8'h77);
    step("write_a_last",      1'b1, 4'hA, 8'h5A, 1'b1, 4'h2, 8'h77);

    // Mid-cycle reset with a write still requested; that write must be lost.
    @(negedge clock);
    #1;
    write_address = 4'h3;
    DATA_WRITE    = 8'h55;
    Write_Enable  = 1'b1;
    reset_n       = 1'b0;
    #1;
    async_check("reset_immediate", 8'h00);
    Write_Enable = 1'b0;
    step("read_in_reset", 1'b0, 4'h0, 8'h00, 1'b1, 4'h9, 8'h00);
    @(negedge clock);
    #1;
    reset_n = 1'b1;

    step("post_reset_9", 1'b0, 4'h0, 8'h00, 1'b1, 4'h9, 8'h00);
    step("post_reset_f", 1'b0, 4'h0, 8'h00, 1'b1, 4'hF, 8'h00);
    step("post_reset_1", 1'b0, 4'h0, 8'h00, 1'b1, 4'h1, 8'h00);
    step("post_reset_5", 1'b0, 4'h0, 8'h00, 1'b1, 4'h5, 8'h00);
    step("post_reset_a", 1'b0, 4'h0, 8'h00, 1'b1, 4'hA, 8'h00);
    step("post_reset_3", 1'b0, 4'h0, 8'h00, 1'b1, 4'h3, 8'h00);
    step("write_after_rst", 1'b1, 4'h3, 8'hE1, 1'b0, 4'h0, 8'h00);
    step("read3_after_rst", 1'b0, 4'h0, 8'h00, 1'b1, 4'h3, 8'hE1);

    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
